// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester, single-port memory arbiter.
// Serialises instruction-fetch (I) and data (D) requests onto one downstream
// bus with one transaction outstanding at a time. D has priority, but after
// STARVE_MAX consecutive D grants with I waiting, I is forced through.
// A pipeline flush marks an in-flight fetch so its response is swallowed;
// the bus transaction itself is always allowed to complete.
//
// Ports:
//   clk, rst              clock, asynchronous active-low reset
//   i_req_valid_i/i_addr_i/i_flush_i    fetch request side
//   i_ready_o/i_data_valid_o/i_data_o   fetch accept pulse and response
//   d_req_valid_i/d_addr_i/d_wen_i/d_wdata_i/d_wlen_i  data request side
//   d_ready_o/d_data_valid_o/d_data_o   data accept pulse and response
//   mem_req_valid_o/mem_addr_o/mem_wen_o/mem_wdata_o/mem_wlen_o  downstream request
//   mem_ready_i/mem_rvalid_i/mem_rdata_i  downstream handshake and response
//   busy_o                a transaction is in progress
module mem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 64,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req_valid_i,
  input  logic [ADDR_W-1:0] i_addr_i,
  input  logic              i_flush_i,
  output logic              i_ready_o,
  output logic              i_data_valid_o,
  output logic [DATA_W-1:0] i_data_o,
  input  logic              d_req_valid_i,
  input  logic [ADDR_W-1:0] d_addr_i,
  input  logic              d_wen_i,
  input  logic [DATA_W-1:0] d_wdata_i,
  input  logic [1:0]        d_wlen_i,
  output logic              d_ready_o,
  output logic              d_data_valid_o,
  output logic [DATA_W-1:0] d_data_o,
  output logic              mem_req_valid_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_wen_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  output logic [1:0]        mem_wlen_o,
  input  logic              mem_ready_i,
  input  logic              mem_rvalid_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              busy_o
);

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_MAX);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

  state_t        r_state;
  logic          r_owner_d;   // 1 = current transaction belongs to D
  logic          r_drop;      // swallow the response of the current fetch
  logic [SW-1:0] r_starve;    // consecutive D grants while I was waiting

  logic w_starved;
  logic w_grant_d;
  logic w_grant_i;
  logic w_flush_owned;

  // Grant decision for the IDLE state and flush qualification.
  always_comb begin
    w_starved     = i_req_valid_i && (r_starve == STARVE_TOP);
    w_grant_d     = d_req_valid_i && !w_starved;
    w_grant_i     = i_req_valid_i && !w_grant_d;
    w_flush_owned = i_flush_i && !r_owner_d;
  end

  assign busy_o = (r_state != ST_IDLE);

  // Arbiter FSM with registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state         <= ST_IDLE;
      r_owner_d       <= 1'b0;
      r_drop          <= 1'b0;
      r_starve        <= '0;
      i_ready_o       <= 1'b0;
      i_data_valid_o  <= 1'b0;
      i_data_o        <= '0;
      d_ready_o       <= 1'b0;
      d_data_valid_o  <= 1'b0;
      d_data_o        <= '0;
      mem_req_valid_o <= 1'b0;
      mem_addr_o      <= '0;
      mem_wen_o       <= 1'b0;
      mem_wdata_o     <= '0;
      mem_wlen_o      <= 2'd0;
    end else begin
      // Handshake and response strobes are single-cycle pulses.
      i_ready_o      <= 1'b0;
      d_ready_o      <= 1'b0;
      i_data_valid_o <= 1'b0;
      d_data_valid_o <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_grant_d) begin
            mem_addr_o      <= d_addr_i;
            mem_wen_o       <= d_wen_i;
            mem_wdata_o     <= d_wdata_i;
            mem_wlen_o      <= d_wlen_i;
            mem_req_valid_o <= 1'b1;
            d_ready_o       <= 1'b1;
            r_owner_d       <= 1'b1;
            r_drop          <= 1'b0;
            r_state         <= ST_ISSUE;
          end else if (w_grant_i) begin
            // Fetches are always full-word loads.
            mem_addr_o      <= i_addr_i;
            mem_wen_o       <= 1'b0;
            mem_wdata_o     <= '0;
            mem_wlen_o      <= 2'd2;
            mem_req_valid_o <= 1'b1;
            i_ready_o       <= 1'b1;
            r_owner_d       <= 1'b0;
            r_drop          <= i_flush_i;
            r_state         <= ST_ISSUE;
          end else begin
            r_state <= ST_IDLE;
          end
          // Counter only tracks D wins over a waiting I; saturates at the top.
          if (!i_req_valid_i || w_grant_i) begin
            r_starve <= '0;
          end else if (w_grant_d && (r_starve != STARVE_TOP)) begin
            r_starve <= r_starve + SW'(1);
          end else begin
            r_starve <= r_starve;
          end
        end
        ST_ISSUE: begin
          if (w_flush_owned) begin
            r_drop <= 1'b1;
          end
          if (mem_ready_i) begin
            mem_req_valid_o <= 1'b0;
            r_state         <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (mem_rvalid_i) begin
            // A flush arriving with the response still discards it.
            if (r_owner_d) begin
              d_data_o       <= mem_wen_o ? '0 : mem_rdata_i;
              d_data_valid_o <= 1'b1;
            end else if (!(r_drop || i_flush_i)) begin
              i_data_o       <= mem_rdata_i;
              i_data_valid_o <= 1'b1;
            end
            r_state <= ST_IDLE;
          end else if (w_flush_owned) begin
            r_drop <= 1'b1;
          end
        end
        default: begin
          mem_req_valid_o <= 1'b0;
          r_state         <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: a per-cycle vector table plus
// hand-written sequences for reset and the starvation guard.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req_valid_i;
  logic [31:0] i_addr_i;
  logic        i_flush_i;
  logic        i_ready_o;
  logic        i_data_valid_o;
  logic [63:0] i_data_o;
  logic        d_req_valid_i;
  logic [31:0] d_addr_i;
  logic        d_wen_i;
  logic [63:0] d_wdata_i;
  logic [1:0]  d_wlen_i;
  logic        d_ready_o;
  logic        d_data_valid_o;
  logic [63:0] d_data_o;
  logic        mem_req_valid_o;
  logic [31:0] mem_addr_o;
  logic        mem_wen_o;
  logic [63:0] mem_wdata_o;
  logic [1:0]  mem_wlen_o;
  logic        mem_ready_i;
  logic        mem_rvalid_i;
  logic [63:0] mem_rdata_i;
  logic        busy_o;

  int n_vec = 0;
  int n_bad = 0;

  localparam logic [63:0] D0 = 64'hDEAD_BEEF_CAFE_F00D;
  localparam logic [63:0] I1 = 64'h1111_2222_3333_4444;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(32), .DATA_W(64), .STARVE_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .i_req_valid_i(i_req_valid_i), .i_addr_i(i_addr_i), .i_flush_i(i_flush_i),
    .i_ready_o(i_ready_o), .i_data_valid_o(i_data_valid_o), .i_data_o(i_data_o),
    .d_req_valid_i(d_req_valid_i), .d_addr_i(d_addr_i), .d_wen_i(d_wen_i),
    .d_wdata_i(d_wdata_i), .d_wlen_i(d_wlen_i),
    .d_ready_o(d_ready_o), .d_data_valid_o(d_data_valid_o), .d_data_o(d_data_o),
    .mem_req_valid_o(mem_req_valid_o), .mem_addr_o(mem_addr_o), .mem_wen_o(mem_wen_o),
    .mem_wdata_o(mem_wdata_o), .mem_wlen_o(mem_wlen_o),
    .mem_ready_i(mem_ready_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
    .busy_o(busy_o)
  );

  wire [133:0] w_core = {i_ready_o, i_data_valid_o, i_data_o, d_ready_o, d_data_valid_o,
                         d_data_o, mem_req_valid_o, busy_o};
  wire [98:0]  w_mem  = {mem_addr_o, mem_wen_o, mem_wdata_o, mem_wlen_o};

  typedef struct {
    logic        ireq;   logic [31:0] iaddr;  logic iflush;
    logic        dreq;   logic [31:0] daddr;  logic dwen; logic [63:0] dwdata; logic [1:0] dwlen;
    logic        mready; logic        mrvalid; logic [63:0] mrdata;
    logic        e_iready; logic e_ivalid; logic [63:0] e_idata;
    logic        e_dready; logic e_dvalid; logic [63:0] e_ddata;
    logic        e_mvalid; logic [31:0] e_maddr; logic e_mwen; logic [63:0] e_mwdata; logic [1:0] e_mwlen;
    logic        e_busy;
  } vec_t;

  localparam int NV = 24;
  vec_t tv [NV];

  function automatic vec_t mk(
    input logic ireq, input logic [31:0] iaddr, input logic iflush,
    input logic dreq, input logic [31:0] daddr, input logic dwen, input logic [63:0] dwdata,
    input logic [1:0] dwlen, input logic mready, input logic mrvalid, input logic [63:0] mrdata,
    input logic e_iready, input logic e_ivalid, input logic [63:0] e_idata,
    input logic e_dready, input logic e_dvalid, input logic [63:0] e_ddata,
    input logic e_mvalid, input logic [31:0] e_maddr, input logic e_mwen,
    input logic [63:0] e_mwdata, input logic [1:0] e_mwlen, input logic e_busy);
    vec_t v;
    v.ireq = ireq; v.iaddr = iaddr; v.iflush = iflush;
    v.dreq = dreq; v.daddr = daddr; v.dwen = dwen; v.dwdata = dwdata; v.dwlen = dwlen;
    v.mready = mready; v.mrvalid = mrvalid; v.mrdata = mrdata;
    v.e_iready = e_iready; v.e_ivalid = e_ivalid; v.e_idata = e_idata;
    v.e_dready = e_dready; v.e_dvalid = e_dvalid; v.e_ddata = e_ddata;
    v.e_mvalid = e_mvalid; v.e_maddr = e_maddr; v.e_mwen = e_mwen;
    v.e_mwdata = e_mwdata; v.e_mwlen = e_mwlen; v.e_busy = e_busy;
    return v;
  endfunction

  task automatic idle_inputs();
    i_req_valid_i = 1'b0; i_addr_i = 32'h0; i_flush_i = 1'b0;
    d_req_valid_i = 1'b0; d_addr_i = 32'h0; d_wen_i = 1'b0; d_wdata_i = 64'h0; d_wlen_i = 2'd0;
    mem_ready_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = 64'h0;
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b want %b", name, act, exp);
    end
  endtask

  logic [133:0] exp_core;
  logic [98:0]  exp_mem;
  logic         exp_order [10];
  int           grants;

  initial begin
    // Row fields: inputs {I: req addr flush | D: req addr wen wdata wlen | mem: ready rvalid rdata}
    // then expected {I: ready dvalid data | D: ready dvalid data | mem: valid addr wen wdata wlen | busy}
    // Single load, mem_ready in the ready cycle, rvalid one cycle later.
    tv[0]  = mk(1'b0, 32'h0, 1'b0, 1'b1, 32'h8000_0010, 1'b0, 64'h0, 2'd3, 1'b0, 1'b0, 64'h0,  1'b0, 1'b0, 64'h0, 1'b1, 1'b0, 64'h0, 1'b1, 32'h8000_0010, 1'b0, 64'h0, 2'd3, 1'b1);
    tv[1]  = mk(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 64'h0, 2'd0, 1'b1, 1'b0, 64'h0,          1'b0, 1'b0, 64'h0, 1'b0, 1'b0, 64'h0, 1'b0, 32'h0, 1'b0, 64'h0, 2'd0, 1'b1);
    tv[2]  = mk(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 64'h0, 2'd0, 1'b0, 1'b1, D0,             1'b0, 1'b0, 64'h0, 1'b0, 1'b1, D0, 1'b0, 32'h0, 1'b0, 64'h0, 2'd0, 1'b0);
    tv[3]  = mk(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 64'h0, 2'd0, 1'b0, 1'b0, 64'h0,          1'b0, 1'b0, 64'h0, 1'b0, 1'b0, D0, 1'b0, 32'h0, 1'b0, 64'h0, 2'd0, 1'b0);
    // Halfword store held through a 3-cycle mem_ready delay, spurious rvalid in ISSUE.
    tv[4]  = mk(1'b0, 32'h0, 1'b0, 1'b1, 32'h100, 1'b1, 64'h1234, 2'd1, 1'b0, 1'b0, 64'h0,    1'b0, 1'b0, 64'h0, 1'b1, 1'b0, D0, 1'b1, 32'h100, 1'b1, 64'h1234, 2'd1, 1'b1);
    tv[5]  = mk(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 64'h0, 2'd0, 1'b0, 1'b0, 64'h0,          1'b0, 1'b0, 64'h0, 1'b0, 1'b0, D0, 1'b1, 32'h100, 1'b1, 64'h1234, 2'd1, 1'b1);
    tv[6]  = mk(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 64'h0, 2'd0, 1'b0, 1'b1, 64'hFFFF,       1'b0, 1'b0, 64'h0, 1'b0, 1'b0, D0, 1'b1, 32'h100, 1'b1, 64'h1234, 2'd1, 1'b1);
    tv[7]  = mk(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 64'h0, 2'd0, 1'b0, 1'b0, 64'h0,          1'b0, 1'b0, 64'h0, 1'b0, 1'b0, D0, 1'b1, 32'h100, 1'b1, 64'h1234, 2'd1, 1'b1);
    tv[8]  = mk(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 64'h0, 2'd0, 1'b1, 1'b0, 64'h0,          1'b0, 1'b0, 64'h0, 1'b0, 1'b0, D0, 1'b0, 32'h0, 1'b0, 64'h0, 2'd0, 1'b1);
    tv[9]  = mk(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 64'h0, 2'd0, 1'b0, 1'b1, 64'hFFFF,       1'b0, 1'b0, 64'h0, 1'b0, 1'b1, 64'h0, 1'b0, 32'h0, 1'b0, 64'h0, 2'd0, 1'b0);
    // Spurious ready/rvalid in IDLE.
    tv[10] = mk(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 64'h0, 2'd0, 1'b1, 1'b1, 64'hAAAA,       1'b0, 1'b0, 64'h0, 1'b0, 1'b0, 64'h0, 1'b0, 32'h0, 1'b0, 64'h0, 2'd0, 1'b0);
    // Fetch flushed during ISSUE: bus completes, no response.
    tv[11] = mk(1'b1, 32'h200, 1'b0, 1'b0, 32'h0, 1'b0, 64'h0, 2'd0, 1'b0, 1'b0, 64'h0,        1'b1, 1'b0, 64'h0, 1'b0, 1'b0, 64'h0, 1'b1, 32'h200, 1'b0, 64'h0, 2'd2, 1'b1);
    tv[12] = mk(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 64'h0, 2'd0, 1'b0, 1'b0, 64'h0,          1'b0, 1'b0, 64'h0, 1'b0, 1'b0, 64'h0, 1'b1, 32'h200, 1'b0, 64'h0, 2'd2, 1'b1);
    tv[13] = mk(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 64'h0, 2'd0, 1'b1, 1'b0, 64'h0,          1'b0, 1'b0, 64'h0, 1'b0, 1'b0, 64'h0, 1'b0, 32'h0, 1'b0, 64'h0, 2'd0, 1'b1);
    tv[14] = mk(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 64'h0, 2'd0, 1'b0, 1'b1, 64'h5555,       1'b0, 1'b0, 64'h0, 1'b0, 1'b0, 64'h0, 1'b0, 32'h0, 1'b0, 64'h0, 2'd0, 1'b0);
    // Next fetch served normally.
    tv[15] = mk(1'b1, 32'h204, 1'b0, 1'b0, 32'h0, 1'b0, 64'h0, 2'd0, 1'b0, 1'b0, 64'h0,        1'b1, 1'b0, 64'h0, 1'b0, 1'b0, 64'h0, 1'b1, 32'h204, 1'b0, 64'h0, 2'd2, 1'b1);
    tv[16] = mk(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 64'h0, 2'd0, 1'b1, 1'b0, 64'h0,          1'b0, 1'b0, 64'h0, 1'b0, 1'b0, 64'h0, 1'b0, 32'h0, 1'b0, 64'h0, 2'd0, 1'b1);
    tv[17] = mk(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 64'h0, 2'd0, 1'b0, 1'b1, I1,             1'b0, 1'b1, I1, 1'b0, 1'b0, 64'h0, 1'b0, 32'h0, 1'b0, 64'h0, 2'd0, 1'b0);
    // Flush in the granting cycle.
    tv[18] = mk(1'b1, 32'h208, 1'b1, 1'b0, 32'h0, 1'b0, 64'h0, 2'd0, 1'b0, 1'b0, 64'h0,        1'b1, 1'b0, I1, 1'b0, 1'b0, 64'h0, 1'b1, 32'h208, 1'b0, 64'h0, 2'd2, 1'b1);
    tv[19] = mk(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 64'h0, 2'd0, 1'b1, 1'b0, 64'h0,          1'b0, 1'b0, I1, 1'b0, 1'b0, 64'h0, 1'b0, 32'h0, 1'b0, 64'h0, 2'd0, 1'b1);
    tv[20] = mk(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 64'h0, 2'd0, 1'b0, 1'b1, 64'h9999,       1'b0, 1'b0, I1, 1'b0, 1'b0, 64'h0, 1'b0, 32'h0, 1'b0, 64'h0, 2'd0, 1'b0);
    // Flush while D owns the bus has no effect.
    tv[21] = mk(1'b0, 32'h0, 1'b1, 1'b1, 32'h300, 1'b0, 64'h0, 2'd2, 1'b0, 1'b0, 64'h0,        1'b0, 1'b0, I1, 1'b1, 1'b0, 64'h0, 1'b1, 32'h300, 1'b0, 64'h0, 2'd2, 1'b1);
    tv[22] = mk(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 64'h0, 2'd0, 1'b1, 1'b0, 64'h0,          1'b0, 1'b0, I1, 1'b0, 1'b0, 64'h0, 1'b0, 32'h0, 1'b0, 64'h0, 2'd0, 1'b1);
    tv[23] = mk(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 64'h0, 2'd0, 1'b0, 1'b1, 64'h77,         1'b0, 1'b0, I1, 1'b0, 1'b1, 64'h77, 1'b0, 32'h0, 1'b0, 64'h0, 2'd0, 1'b0);

    exp_order = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    // Reset held with requests pending: every output low.
    rst = 1'b0;
    idle_inputs();
    i_req_valid_i = 1'b1; d_req_valid_i = 1'b1;
    #2;
    n_vec++;
    if ({w_core, w_mem} !== 233'h0) begin
      n_bad++; $display("FAIL reset_state: got %h want 0", {w_core, w_mem});
    end

    // Load reaches RESP, then reset mid-cycle abandons it.
    @(negedge clk);
    rst = 1'b1; i_req_valid_i = 1'b0; d_addr_i = 32'h40;
    @(posedge clk); #1;
    check_bit("mid_reset_grant", d_ready_o, 1'b1);
    @(negedge clk);
    d_req_valid_i = 1'b0; mem_ready_i = 1'b1;
    @(negedge clk);
    mem_ready_i = 1'b0;
    #2 rst = 1'b0;
    #1;
    n_vec++;
    if ({w_core, w_mem} !== 233'h0) begin
      n_bad++; $display("FAIL reset_mid_resp: got %h want 0", {w_core, w_mem});
    end
    mem_rvalid_i = 1'b1; mem_rdata_i = 64'h1;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check_bit("no_dvalid_after_reset", d_data_valid_o, 1'b0);
    @(posedge clk); #1;
    check_bit("idle_after_reset", busy_o, 1'b0);

    // Table-driven vectors: one vector per clock.
    for (int k = 0; k < NV; k++) begin
      @(negedge clk);
      i_req_valid_i = tv[k].ireq; i_addr_i = tv[k].iaddr; i_flush_i = tv[k].iflush;
      d_req_valid_i = tv[k].dreq; d_addr_i = tv[k].daddr; d_wen_i = tv[k].dwen;
      d_wdata_i = tv[k].dwdata; d_wlen_i = tv[k].dwlen;
      mem_ready_i = tv[k].mready; mem_rvalid_i = tv[k].mrvalid; mem_rdata_i = tv[k].mrdata;
      @(posedge clk); #1;
      exp_core = {tv[k].e_iready, tv[k].e_ivalid, tv[k].e_idata, tv[k].e_dready, tv[k].e_dvalid,
                  tv[k].e_ddata, tv[k].e_mvalid, tv[k].e_busy};
      exp_mem  = {tv[k].e_maddr, tv[k].e_mwen, tv[k].e_mwdata, tv[k].e_mwlen};
      n_vec++;
      if (w_core !== exp_core || (tv[k].e_mvalid && w_mem !== exp_mem)) begin
        n_bad++;
        $display("FAIL vec%0d: core got %h want %h, mem got %h want %h", k, w_core, exp_core, w_mem, exp_mem);
      end
    end

    // Starvation guard: both sides request every cycle, memory answers at once.
    @(negedge clk);
    idle_inputs();
    i_req_valid_i = 1'b1; i_addr_i = 32'h400;
    d_req_valid_i = 1'b1; d_addr_i = 32'h500; d_wlen_i = 2'd3;
    mem_ready_i = 1'b1; mem_rvalid_i = 1'b1; mem_rdata_i = 64'h42;
    grants = 0;
    for (int c = 0; c < 60 && grants < 10; c++) begin
      @(posedge clk); #1;
      if (i_ready_o && d_ready_o) begin
        n_vec++; n_bad++;
        $display("FAIL double_grant: i_ready=1 d_ready=1 want one");
      end else if (i_ready_o || d_ready_o) begin
        check_bit($sformatf("grant%0d_is_i", grants), i_ready_o, exp_order[grants]);
        grants++;
      end
    end
    if (grants < 10) begin
      n_vec++; n_bad++;
      $display("FAIL starve_timeout: got %0d grants want 10", grants);
    end
    @(negedge clk);
    idle_inputs();
    repeat (3) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester, single-port memory arbiter between the core's instruction-fetch port (PC/IF_ID side) and its data port (ID/MEM side) and one shared downstream memory bus. It serialises one outstanding transaction at a time and returns responses to the originating side. Data requests take priority, with a starvation guard so instruction fetch always makes progress. Pipeline flushes discard in-flight fetch responses.

## Interface
- ADDR_W, 32, address width
- DATA_W, 64, data width (matches register/data bus)
- STARVE_MAX, 4, consecutive D grants allowed while I is pending before I is forced (≥1)

- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- i_req_valid_i  in  1  fetch request; held until i_ready_o
- i_addr_i  in  ADDR_W  fetch address
- i_flush_i  in  1  discard any granted/in-flight fetch response
- i_ready_o  out  1  one-cycle pulse: fetch request accepted
- i_data_valid_o  out  1  one-cycle pulse: fetch data on i_data_o
- i_data_o  out  DATA_W  fetch data
- d_req_valid_i  in  1  data request; held until d_ready_o
- d_addr_i  in  ADDR_W  data address
- d_wen_i  in  1  1 = store
- d_wdata_i  in  DATA_W  store data
- d_wlen_i  in  2  store size: 0=B,1=H,2=W,3=D
- d_ready_o  out  1  one-cycle pulse: data request accepted
- d_data_valid_o  out  1  one-cycle pulse: load data / store done
- d_data_o  out  DATA_W  load data (0 for stores)
- mem_req_valid_o  out  1  downstream request
- mem_addr_o, mem_wen_o, mem_wdata_o, mem_wlen_o  out  ADDR_W/1/DATA_W/2  downstream fields, stable while mem_req_valid_o
- mem_ready_i  in  1  downstream accepts request this cycle
- mem_rvalid_i  in  1  downstream response (load data or store ack)
- mem_rdata_i  in  DATA_W  response data
- busy_o  out  1  state ≠ IDLE

## Operation
- States: IDLE, ISSUE, RESP. Registers: state, owner (I/D), drop flag, starve counter (width clog2(STARVE_MAX+1)).
- IDLE: grant = D if d_req_valid_i and not (i_req_valid_i and starve == STARVE_MAX); else I if i_req_valid_i. On grant: capture fields into mem_* regs, mem_req_valid_o←1, pulse owner's ready, owner←grant, drop←(grant==I & i_flush_i), → ISSUE.
- Starve counter: +1 on D grant while i_req_valid_i=1; cleared on I grant or whenever i_req_valid_i=0 in IDLE; saturates at STARVE_MAX.
- I-side captured mem_wen/wdata/wlen = 0/0/2.
- ISSUE: mem_* held. On mem_ready_i: mem_req_valid_o←0, → RESP.
- RESP: on mem_rvalid_i: if not drop, owner's data_o←mem_rdata_i (0 for store) and data_valid pulses; → IDLE.
- drop set by i_flush_i in any cycle with owner=I in ISSUE/RESP, and by flush in the granting cycle; flush never aborts the bus transaction. Flush with owner=D: no effect.
- mem_rvalid_i in IDLE/ISSUE: ignored. mem_ready_i outside ISSUE: ignored.
- A requester whose req_valid drops before grant is simply not granted.

## Timing
- Reset (rst=0, async): state IDLE, all outputs 0, starve 0, drop 0; mid-transaction reset abandons it without any response pulse.
- Request seen in IDLE cycle N → ready pulse and mem_req_valid_o high cycle N+1.
- mem_ready_i in cycle M (ISSUE) → mem_req_valid_o low M+1, state RESP M+1.
- mem_rvalid_i in cycle R (RESP) → data_valid pulse and data R+1, state IDLE R+1; next grant earliest visible R+2.
- Minimum request-to-data: 3 cycles (ready at N+1, rvalid at N+2). Max one outstanding transaction.
- data_o holds last value between pulses.

## Test plan
- Reset: drive requests, pull rst low mid-RESP → all outputs 0 immediately, no data_valid after release.
- Single load: d_addr=0x80000010, mem_ready same cycle, rvalid 1 cycle later, rdata=0xDEADBEEF_CAFEF00D → d_ready at N+1, d_data_valid at N+3 with that data.
- Simultaneous I and D each cycle, STARVE_MAX=4 → grant order D,D,D,D,I,D,D,D,D,I…; no I starvation.
- Store: d_wen=1, wlen=1, wdata=0x1234 → mem_wen_o=1, mem_wlen_o=1, held through 3-cycle mem_ready delay; d_data_valid pulse with d_data_o=0.
- Flush: I granted, i_flush_i pulsed in ISSUE → bus completes, no i_data_valid_o; next I request served normally.
- Spurious mem_rvalid_i in IDLE and ISSUE → no data_valid, state unaffected.
